// File: rtl/inst_mem_pipe.sv
`default_nettype none
// inst_mem_pipe: word-addressed instruction memory with a LATENCY-stage stallable read pipeline and a load port.
// Optional IMEM_ALIGN_CHECK_EN: misaligned/out-of-range fetches return NOP with addr_fault set.  Rev 1.0
module inst_mem_pipe #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       instruction,
  output logic              inst_valid,
  output logic              addr_fault
);
  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP_WORD = 32'hE1A00000;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_idx;
  logic             load_en;
  logic             accept;
  logic             fetch_fault;
  logic [31:0]      raw_word;
  logic [31:0]      read_word;
  logic             unused_addr_bits;

  assign fetch_idx = fetch_addr[IDX_W+1:2];
  assign load_idx  = load_addr[IDX_W+1:2];
  assign load_en   = load_we & ~rst;
  assign accept    = fetch_req & ~stall;
  assign unused_addr_bits = ^{fetch_addr, load_addr};

`ifdef IMEM_ALIGN_CHECK_EN
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);
  assign fetch_fault = (fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_addr} >= ADDR_LIMIT);
`else
  assign fetch_fault = 1'b0;
`endif

  // Write-first: a same-cycle load to the fetched word is forwarded into the pipeline.
  assign raw_word  = (load_en && (load_idx == fetch_idx)) ? load_data : mem[fetch_idx];
  assign read_word = fetch_fault ? NOP_WORD : raw_word;

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  logic [LATENCY-1:0][31:0] stage_data;
  logic [LATENCY-1:0]       stage_vld;
  logic [LATENCY-1:0]       stage_flt;
  logic [LATENCY-1:0][31:0] in_data;
  logic [LATENCY-1:0]       in_vld;
  logic [LATENCY-1:0]       in_flt;

  always_comb begin
    in_data    = '0;
    in_vld     = '0;
    in_flt     = '0;
    in_data[0] = read_word;
    in_vld[0]  = accept;
    in_flt[0]  = fetch_fault;
    for (int k = 1; k < LATENCY; k++) begin
      in_data[k] = stage_data[k-1];
      in_vld[k]  = stage_vld[k-1];
      in_flt[k]  = stage_flt[k-1];
    end
  end

  // Data only moves with a valid token, so the last stage holds the last delivered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_data <= '0;
      stage_vld  <= '0;
      stage_flt  <= '0;
    end else if (!stall) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_vld[k] <= in_vld[k];
        if (in_vld[k]) begin
          stage_data[k] <= in_data[k];
          stage_flt[k]  <= in_flt[k];
        end else begin
          stage_flt[k]  <= 1'b0;
        end
      end
    end
  end

  assign instruction = stage_data[LATENCY-1];
  assign inst_valid  = stage_vld[LATENCY-1];
  assign addr_fault  = stage_flt[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_pipe.sv
`default_nettype none
// tb_inst_mem_pipe: LATENCY=2 and LATENCY=3 instances on shared stimulus, checked against a token-log reference model.
module tb_inst_mem_pipe;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        stall = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic [31:0] inst2, inst3;
  logic        vld2, vld3, flt2, flt3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_mem_pipe #(.DEPTH_WORDS(256), .LATENCY(2), .ADDR_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .instruction(inst2), .inst_valid(vld2), .addr_fault(flt2));

  inst_mem_pipe #(.DEPTH_WORDS(256), .LATENCY(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .instruction(inst3), .inst_valid(vld3), .addr_fault(flt3));

  // Reference model: every accepted fetch is logged against the count of non-stalled edges;
  // a fetch logged at count a emerges when the count reaches a + LATENCY - 1.
  logic [31:0] mdl_mem [256];
  logic [31:0] log_data [int];
  bit          log_flt [int];
  int          active = 0;
  logic [31:0] exp_inst [2];
  logic        exp_vld [2];
  logic        exp_flt [2];

  always @(posedge clk) begin
    int unsigned fi;
    logic [31:0] d;
    bit          f;
    if (rst) begin
      log_data.delete();
      log_flt.delete();
      for (int j = 0; j < 2; j++) begin
        exp_inst[j] = 32'h0; exp_vld[j] = 1'b0; exp_flt[j] = 1'b0;
      end
    end else begin
      if (!stall) begin
        active++;
        if (fetch_req) begin
          fi = (fetch_addr / 4) % 256;
          d  = mdl_mem[fi];
          if (load_we && ((load_addr / 4) % 256) == fi) d = load_data;
          f = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
          if ((fetch_addr % 4) != 0 || fetch_addr >= 32'd1024) begin
            f = 1'b1; d = NOP;
          end
`endif
          log_data[active] = d;
          log_flt[active]  = f;
        end
        for (int j = 0; j < 2; j++) begin
          if (log_data.exists(active - (j + 1))) begin
            exp_inst[j] = log_data[active - (j + 1)];
            exp_vld[j]  = 1'b1;
            exp_flt[j]  = log_flt[active - (j + 1)];
          end else begin
            exp_vld[j] = 1'b0;
            exp_flt[j] = 1'b0;
          end
        end
      end
      if (load_we) mdl_mem[(load_addr / 4) % 256] = load_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    fetch_req = 1'b0; stall = 1'b0; load_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    tests++;
    if ({inst2, vld2, flt2} !== 34'h0) begin
      fails++;
      $display("FAIL reset_l2: got inst=%h v=%b f=%b, want 0/0/0", inst2, vld2, flt2);
    end
    tests++;
    if ({inst3, vld3, flt3} !== 34'h0) begin
      fails++;
      $display("FAIL reset_l3: got inst=%h v=%b f=%b, want 0/0/0", inst3, vld3, flt3);
    end
    rst = 1'b0;
  endtask

  task automatic test_preload();
    for (int i = 0; i < 256; i++) begin
      load_we   = 1'b1;
      load_addr = ($urandom_range(0, 15) << 10) | (i << 2) | $urandom_range(0, 3);
      load_data = $urandom;
      tick();
      tests++;
      if ({inst2, vld2, flt2} !== {exp_inst[0], exp_vld[0], exp_flt[0]}) begin
        fails++;
        $display("FAIL preload_l2 word %0d: got %h/%b/%b want %h/%b/%b", i, inst2, vld2, flt2, exp_inst[0], exp_vld[0], exp_flt[0]);
      end
    end
    load_we = 1'b0;
  endtask

  task automatic test_latency();
    load_we = 1'b1; load_addr = 32'h0; load_data = 32'hE3A00014;
    tick();
    load_we = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tests++;
      if (vld2 !== (c == 2) || (c >= 2 && inst2 !== 32'hE3A00014)) begin
        fails++;
        $display("FAIL latency_l2 cycle N+%0d: got v=%b inst=%h want v=%b inst=E3A00014", c, vld2, inst2, (c == 2));
      end
      tests++;
      if (vld3 !== (c == 3) || (c >= 3 && inst3 !== 32'hE3A00014)) begin
        fails++;
        $display("FAIL latency_l3 cycle N+%0d: got v=%b inst=%h want v=%b inst=E3A00014", c, vld3, inst3, (c == 3));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    logic [31:0] got [$];
    int          at [$];
    bit          stl [6] = '{0, 1, 1, 0, 0, 0};
    bit          req [6] = '{1, 1, 1, 1, 1, 0};
    logic [31:0] adr [6] = '{0, 4, 4, 4, 8, 0};
    for (int i = 0; i < 3; i++) want[i] = mdl_mem[i];
    for (int k = 0; k < 9; k++) begin
      fetch_req  = (k < 6) ? req[k] : 1'b0;
      stall      = (k < 6) ? stl[k] : 1'b0;
      fetch_addr = (k < 6) ? adr[k] : 32'h0;
      tick();
      if (vld2) begin got.push_back(inst2); at.push_back(k); end
      tests++;
      if ({inst2, vld2, flt2} !== {exp_inst[0], exp_vld[0], exp_flt[0]}) begin
        fails++;
        $display("FAIL b2b_l2 step %0d: got %h/%b/%b want %h/%b/%b", k, inst2, vld2, flt2, exp_inst[0], exp_vld[0], exp_flt[0]);
      end
      tests++;
      if ({inst3, vld3, flt3} !== {exp_inst[1], exp_vld[1], exp_flt[1]}) begin
        fails++;
        $display("FAIL b2b_l3 step %0d: got %h/%b/%b want %h/%b/%b", k, inst3, vld3, flt3, exp_inst[1], exp_vld[1], exp_flt[1]);
      end
    end
    tests++;
    if (got.size() != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d results, want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got[i] !== want[i] || at[i] != 3 + i) begin
          fails++;
          $display("FAIL b2b_order result %0d: got %h at step %0d, want %h at step %0d", i, got[i], at[i], want[i], 3 + i);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_write_first();
    load_we = 1'b1; load_addr = 32'd8; load_data = 32'h12345678;
    fetch_req = 1'b1; fetch_addr = 32'd8;
    tick();
    set_idle();
    tick();
    tests++;
    if (vld2 !== 1'b1 || inst2 !== 32'h12345678) begin
      fails++;
      $display("FAIL write_first_l2: got v=%b inst=%h want 1/12345678", vld2, inst2);
    end
    tick();
    tests++;
    if (vld3 !== 1'b1 || inst3 !== 32'h12345678) begin
      fails++;
      $display("FAIL write_first_l3: got v=%b inst=%h want 1/12345678", vld3, inst3);
    end
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] old3;
    logic [31:0] word4;
    old3  = mdl_mem[3];
    word4 = mdl_mem[4];
    fetch_req = 1'b1; fetch_addr = 32'd12;
    tick();
    fetch_req = 1'b0; rst = 1'b1;
    load_we = 1'b1; load_addr = 32'd12; load_data = ~old3;
    tick();
    rst = 1'b0; load_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tests++;
      if (vld3 !== 1'b0 || inst3 !== 32'h0 || vld2 !== 1'b0 || inst2 !== 32'h0) begin
        fails++;
        $display("FAIL flush cycle %0d: got l3 %b/%h l2 %b/%h want 0/00000000", c, vld3, inst3, vld2, inst2);
      end
      tick();
    end
    fetch_req = 1'b1; fetch_addr = 32'd12;
    tick();
    fetch_req = 1'b0;
    tick();
    tests++;
    if (vld2 !== 1'b1 || inst2 !== old3) begin
      fails++;
      $display("FAIL load_in_reset: got v=%b inst=%h want 1/%h", vld2, inst2, old3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; fetch_req = 1'b1; fetch_addr = 32'd16;
    tick();
    fetch_req = 1'b0;
    tick();
    tests++;
    if (vld2 !== 1'b1 || inst2 !== word4) begin
      fails++;
      $display("FAIL first_after_reset: got v=%b inst=%h want 1/%h", vld2, inst2, word4);
    end
  endtask

  task automatic test_addr_check();
    logic [31:0] gi [2];
    logic        gv [2];
    logic        gf [2];
    logic [31:0] wi [2];
    logic        wf;
`ifdef IMEM_ALIGN_CHECK_EN
    wi[0] = NOP; wi[1] = NOP; wf = 1'b1;
`else
    wi[0] = mdl_mem[0]; wi[1] = mdl_mem[1]; wf = 1'b0;
`endif
    fetch_req = 1'b1; fetch_addr = 32'd1024;
    tick();
    fetch_addr = 32'd6;
    tick();
    fetch_req = 1'b0;
    gi[0] = inst2; gv[0] = vld2; gf[0] = flt2;
    tick();
    gi[1] = inst2; gv[1] = vld2; gf[1] = flt2;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (gv[i] !== 1'b1 || gi[i] !== wi[i] || gf[i] !== wf) begin
        fails++;
        $display("FAIL addr_check %0d: got v=%b inst=%h f=%b want 1/%h/%b", i, gv[i], gi[i], gf[i], wi[i], wf);
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 59) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      fetch_req = ($urandom_range(0, 9) < 7);
`ifdef IMEM_ALIGN_CHECK_EN
      fetch_addr = $urandom_range(0, 1100);
`else
      fetch_addr = $urandom;
`endif
      load_we   = ($urandom_range(0, 4) == 0);
      load_addr = $urandom;
      load_data = $urandom;
      tick();
      tests++;
      if ({inst2, vld2, flt2} !== {exp_inst[0], exp_vld[0], exp_flt[0]}) begin
        fails++;
        $display("FAIL random_l2 step %0d: got %h/%b/%b want %h/%b/%b", k, inst2, vld2, flt2, exp_inst[0], exp_vld[0], exp_flt[0]);
      end
      tests++;
      if ({inst3, vld3, flt3} !== {exp_inst[1], exp_vld[1], exp_flt[1]}) begin
        fails++;
        $display("FAIL random_l3 step %0d: got %h/%b/%b want %h/%b/%b", k, inst3, vld3, flt3, exp_inst[1], exp_vld[1], exp_flt[1]);
      end
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_latency();
    test_back_to_back();
    test_write_first();
    test_reset_in_flight();
    test_addr_check();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
